// File: rtl/y86_alu_pipe.sv
// y86_alu_pipe: registered Y86 OPq ALU (ADD/SUB/AND/XOR) holding the ZF/SF/OF
// condition codes, with a one-entry valid/ready pipe register.
// Ports:
//   i_clk, i_rst_n         clock; synchronous active-low reset
//   i_in_valid, o_in_ready upstream handshake (o_in_ready = !o_out_valid || i_out_ready)
//   i_alu_fun              Y86 ifun: 0=ADD 1=SUB 2=AND 3=XOR, 4..15 illegal
//   i_val_a, i_val_b       operands; the result is b OP a
//   i_set_cc               load condition codes from this operation's flags
//   o_out_valid, i_out_ready downstream handshake
//   o_result, o_fun_err    registered result and illegal-function marker
//   o_cc_zf/sf/of          architectural condition codes
//   o_op_count             legal operations accepted since reset (wrapping)
module y86_alu_pipe #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [3:0]       i_alu_fun,
    input  logic [WIDTH-1:0] i_val_a,
    input  logic [WIDTH-1:0] i_val_b,
    input  logic             i_set_cc,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_fun_err,
    output logic             o_cc_zf,
    output logic             o_cc_sf,
    output logic             o_cc_of,
    output logic [CNT_W-1:0] o_op_count
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_consume;
    logic             w_legal;
    logic [WIDTH-1:0] w_res;
    logic             w_sa;
    logic             w_sb;
    logic             w_sr;
    logic             w_of;
    logic [WIDTH-1:0] r_result;
    logic             r_fun_err;
    logic             r_zf;
    logic             r_sf;
    logic             r_of;
    logic [CNT_W-1:0] r_cnt;
    assign o_out_valid = (r_state == FULL);
    assign o_in_ready  = !o_out_valid || i_out_ready;
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_consume   = o_out_valid && i_out_ready;
    assign w_legal     = (i_alu_fun[3:2] == 2'b00);
    assign w_res = (i_alu_fun == 4'd0) ? i_val_b + i_val_a :
                   (i_alu_fun == 4'd1) ? i_val_b - i_val_a :
                   (i_alu_fun == 4'd2) ? i_val_b & i_val_a :
                   (i_alu_fun == 4'd3) ? i_val_b ^ i_val_a : '0;
    assign w_sa = i_val_a[WIDTH-1];
    assign w_sb = i_val_b[WIDTH-1];
    assign w_sr = w_res[WIDTH-1];
    // Signed overflow: the result sign disagrees with b when the effective operand signs agree
    assign w_of = (i_alu_fun == 4'd0) ? (w_sa == w_sb) && (w_sr != w_sb) :
                  (i_alu_fun == 4'd1) ? (w_sa != w_sb) && (w_sr != w_sb) : 1'b0;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= EMPTY;
        else          r_state <= w_state_nxt;
    end
    // An accept always leaves a result held, even when the old one is consumed in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept)       w_state_nxt = FULL;
        else if (w_consume) w_state_nxt = EMPTY;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_result  <= '0;
            r_fun_err <= 1'b0;
            r_zf      <= 1'b1;
            r_sf      <= 1'b0;
            r_of      <= 1'b0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_result  <= w_legal ? w_res : '0;
            r_fun_err <= !w_legal;
            if (w_legal) r_cnt <= r_cnt + CNT_W'(1);
            if (w_legal && i_set_cc) begin
                r_zf <= (w_res == '0);
                r_sf <= w_sr;
                r_of <= w_of;
            end
        end
    end
    assign o_result   = r_result;
    assign o_fun_err  = r_fun_err;
    assign o_cc_zf    = r_zf;
    assign o_cc_sf    = r_sf;
    assign o_cc_of    = r_of;
    assign o_op_count = r_cnt;
endmodule

// File: tb/tb_y86_alu_pipe.sv
// tb_y86_alu_pipe: randomized self-checking bench for y86_alu_pipe against a behavioural model
module tb_y86_alu_pipe;
    localparam int W = 64;
    localparam int CW = 4;
    localparam logic signed [65:0] MAX_S = (66'sd1 <<< 63) - 66'sd1;
    localparam logic signed [65:0] MIN_S = -(66'sd1 <<< 63);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    alu_fun = 4'd0;
    logic [W-1:0]  val_a = '0;
    logic [W-1:0]  val_b = '0;
    logic          set_cc = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result;
    logic          fun_err;
    logic          cc_zf;
    logic          cc_sf;
    logic          cc_of;
    logic [CW-1:0] op_count;

    int vec = 0;
    int err = 0;

    logic         m_valid = 1'b0;
    logic [W-1:0] m_res = '0;
    logic         m_err = 1'b0;
    logic         m_zf = 1'b1;
    logic         m_sf = 1'b0;
    logic         m_of = 1'b0;
    int           m_cnt = 0;

    y86_alu_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_alu_fun(alu_fun), .i_val_a(val_a), .i_val_b(val_b), .i_set_cc(set_cc),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_result(result),
        .o_fun_err(fun_err), .o_cc_zf(cc_zf), .o_cc_sf(cc_sf), .o_cc_of(cc_of),
        .o_op_count(op_count)
    );

    always #5 clk = ~clk;

    // Reference: exact integer arithmetic, overflow when the true value leaves the signed range
    task automatic ref_op(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output logic zf, output logic sf, output logic of);
        logic signed [65:0] sa;
        logic signed [65:0] sb;
        logic signed [65:0] s;
        sa = {{2{a[W-1]}}, a};
        sb = {{2{b[W-1]}}, b};
        case (f)
            4'd0:    s = sb + sa;
            4'd1:    s = sb - sa;
            4'd2:    s = sb & sa;
            4'd3:    s = sb ^ sa;
            default: s = '0;
        endcase
        r  = s[W-1:0];
        zf = (r == '0);
        sf = r[W-1];
        of = (f < 4'd2) && (s > MAX_S || s < MIN_S);
    endtask

    // Drives one cycle of stimulus and advances the model across the clock edge
    task automatic drive_step(input logic rst, input logic v, input logic [3:0] f,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic sc, input logic ordy);
        logic         acc;
        logic         cons;
        logic [W-1:0] r;
        logic         zf, sf, of;
        rst_n = rst; in_valid = v; alu_fun = f; val_a = a; val_b = b; set_cc = sc; out_ready = ordy;
        acc  = v && (!m_valid || ordy);
        cons = m_valid && ordy;
        ref_op(f, a, b, r, zf, sf, of);
        @(posedge clk);
        if (!rst) begin
            m_valid = 1'b0; m_res = '0; m_err = 1'b0;
            m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0; m_cnt = 0;
        end else if (acc) begin
            m_valid = 1'b1;
            if (f < 4'd4) begin
                m_res = r; m_err = 1'b0; m_cnt = (m_cnt + 1) % (1 << CW);
                if (sc) begin m_zf = zf; m_sf = sf; m_of = of; end
            end else begin
                m_res = '0; m_err = 1'b1;
            end
        end else if (cons) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 5))
            0:       rand_val = 64'h7FFF_FFFF_FFFF_FFFF;
            1:       rand_val = 64'h8000_0000_0000_0000;
            2:       rand_val = '0;
            3:       rand_val = '1;
            default: rand_val = {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [3:0] rand_fun();
        rand_fun = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
    endfunction

    task automatic test_reset();
        drive_step(1'b0, 1'b1, 4'd0, 64'd1, 64'd2, 1'b1, 1'b0);
        drive_step(1'b0, 1'b1, 4'd0, 64'd1, 64'd2, 1'b1, 1'b0);
        vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        vec++; if (cc_zf !== 1'b1) begin err++; $display("FAIL reset_zf got=%b exp=1", cc_zf); end
        vec++; if ({cc_sf, cc_of} !== 2'b00) begin err++; $display("FAIL reset_sf_of got=%b exp=00", {cc_sf, cc_of}); end
        vec++; if (op_count !== '0) begin err++; $display("FAIL reset_count got=%0d exp=0", op_count); end
        vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        vec++; if ({result, fun_err} !== '0) begin err++; $display("FAIL reset_result got=%h/%b exp=0", result, fun_err); end
    endtask

    task automatic test_flags();
        drive_step(1'b1, 1'b1, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        vec++; if (out_valid !== 1'b1) begin err++; $display("FAIL add_valid got=%b exp=1", out_valid); end
        vec++; if (result !== 64'h8000_0000_0000_0000) begin err++; $display("FAIL add_ovf_result got=%h exp=8000000000000000", result); end
        vec++; if ({cc_zf, cc_sf, cc_of} !== 3'b011) begin err++; $display("FAIL add_ovf_cc got=%b exp=011", {cc_zf, cc_sf, cc_of}); end
        vec++; if (op_count !== 4'd1) begin err++; $display("FAIL add_count got=%0d exp=1", op_count); end
        drive_step(1'b1, 1'b1, 4'd1, 64'd5, 64'd5, 1'b1, 1'b1);
        vec++; if (result !== 64'd0) begin err++; $display("FAIL sub_zero_result got=%h exp=0", result); end
        vec++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin err++; $display("FAIL sub_zero_cc got=%b exp=100", {cc_zf, cc_sf, cc_of}); end
        drive_step(1'b1, 1'b1, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 1'b1);
        vec++; if ({result, cc_zf, cc_sf, cc_of} !== {64'h7FFF_FFFF_FFFF_FFFF, 3'b001}) begin
            err++; $display("FAIL sub_ovf got=%h/%b exp=7fffffffffffffff/001", result, {cc_zf, cc_sf, cc_of}); end
    endtask

    task automatic test_logic();
        drive_step(1'b1, 1'b1, 4'd3, 64'h07, 64'h7F, 1'b1, 1'b1);
        vec++; if (result !== 64'h78) begin err++; $display("FAIL xor_result got=%h exp=78", result); end
        vec++; if ({cc_zf, cc_sf, cc_of} !== 3'b000) begin err++; $display("FAIL xor_cc got=%b exp=000", {cc_zf, cc_sf, cc_of}); end
        drive_step(1'b1, 1'b1, 4'd1, 64'd9, 64'd9, 1'b1, 1'b1);
        drive_step(1'b1, 1'b1, 4'd2, 64'h07, 64'h7F, 1'b0, 1'b1);
        vec++; if (result !== 64'h07) begin err++; $display("FAIL and_result got=%h exp=07", result); end
        vec++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin err++; $display("FAIL and_cc_hold got=%b exp=100", {cc_zf, cc_sf, cc_of}); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        drive_step(1'b1, 1'b0, 4'd0, '0, '0, 1'b0, 1'b1);
        drive_step(1'b1, 1'b1, 4'd0, 64'd40, 64'd2, 1'b1, 1'b0);
        held = 64'd42;
        for (int i = 0; i < 5; i++) begin
            drive_step(1'b1, 1'b1, rand_fun(), rand_val(), rand_val(), 1'b1, 1'b0);
            vec++; if (in_ready !== 1'b0) begin err++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
            vec++; if ({out_valid, result, fun_err} !== {1'b1, held, 1'b0}) begin
                err++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%b exp=1/%h/0", i, out_valid, result, fun_err, held); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]   f;
        logic [W-1:0] a, b;
        logic         v, ordy;
        int           n_acc = 0;
        for (int i = 0; i < 100; i++) begin
            f = rand_fun(); a = rand_val(); b = rand_val();
            drive_step(1'b1, 1'b1, f, a, b, 1'($urandom_range(0, 1)), 1'b1);
            vec++; if ({out_valid, result, fun_err} !== {1'b1, m_res, m_err}) begin
                err++; $display("FAIL stream op=%0d f=%0d a=%h b=%h got=%b/%h/%b exp=1/%h/%b", i, f, a, b, out_valid, result, fun_err, m_res, m_err); end
            vec++; if ({cc_zf, cc_sf, cc_of, op_count} !== {m_zf, m_sf, m_of, CW'(m_cnt)}) begin
                err++; $display("FAIL stream_cc op=%0d got=%b/%0d exp=%b/%0d", i, {cc_zf, cc_sf, cc_of}, op_count, {m_zf, m_sf, m_of}, m_cnt); end
        end
        for (int i = 0; i < 80; i++) begin
            v = 1'($urandom_range(0, 1)); ordy = 1'($urandom_range(0, 2) != 0);
            if (v && (!m_valid || ordy)) n_acc++;
            drive_step(1'b1, v, rand_fun(), rand_val(), rand_val(), 1'($urandom_range(0, 1)), ordy);
            vec++; if (in_ready !== (!m_valid || out_ready)) begin
                err++; $display("FAIL mixed_in_ready cyc=%0d got=%b exp=%b", i, in_ready, !m_valid || out_ready); end
            vec++; if (out_valid !== m_valid || (m_valid && {result, fun_err} !== {m_res, m_err})) begin
                err++; $display("FAIL mixed cyc=%0d got=%b/%h/%b exp=%b/%h/%b", i, out_valid, result, fun_err, m_valid, m_res, m_err); end
            vec++; if ({cc_zf, cc_sf, cc_of, op_count} !== {m_zf, m_sf, m_of, CW'(m_cnt)}) begin
                err++; $display("FAIL mixed_cc cyc=%0d got=%b/%0d exp=%b/%0d", i, {cc_zf, cc_sf, cc_of}, op_count, {m_zf, m_sf, m_of}, m_cnt); end
        end
        vec++; if (n_acc == 0) begin err++; $display("FAIL mixed_accepts got=0 exp=nonzero"); end
    endtask

    task automatic test_illegal();
        logic [2:0]    cc0;
        logic [CW-1:0] cnt0;
        drive_step(1'b1, 1'b1, 4'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        cc0 = {m_zf, m_sf, m_of}; cnt0 = CW'(m_cnt);
        drive_step(1'b1, 1'b1, 4'd6, 64'd1, 64'd1, 1'b1, 1'b1);
        vec++; if ({out_valid, result, fun_err} !== {1'b1, 64'd0, 1'b1}) begin
            err++; $display("FAIL illegal_result got=%b/%h/%b exp=1/0/1", out_valid, result, fun_err); end
        vec++; if ({cc_zf, cc_sf, cc_of} !== cc0) begin err++; $display("FAIL illegal_cc got=%b exp=%b", {cc_zf, cc_sf, cc_of}, cc0); end
        vec++; if (op_count !== cnt0) begin err++; $display("FAIL illegal_count got=%0d exp=%0d", op_count, cnt0); end
        drive_step(1'b1, 1'b1, 4'd3, 64'hF0, 64'h0F, 1'b0, 1'b1);
        vec++; if ({result, fun_err} !== {64'hFF, 1'b0}) begin err++; $display("FAIL illegal_clear got=%h/%b exp=ff/0", result, fun_err); end
    endtask

    task automatic test_reset_mid();
        drive_step(1'b1, 1'b1, 4'd0, 64'd1, 64'd1, 1'b1, 1'b0);
        drive_step(1'b1, 1'b1, 4'd0, 64'd1, 64'd1, 1'b1, 1'b0);
        vec++; if (out_valid !== 1'b1) begin err++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
        drive_step(1'b0, 1'b1, 4'd0, 64'd1, 64'd1, 1'b1, 1'b0);
        vec++; if ({out_valid, cc_zf, op_count} !== {1'b1 ^ 1'b1, 1'b1, CW'(0)}) begin
            err++; $display("FAIL mid_reset got=%b/%b/%0d exp=0/1/0", out_valid, cc_zf, op_count); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 17; i++) drive_step(1'b1, 1'b1, 4'($urandom_range(0, 3)), rand_val(), rand_val(), 1'b0, 1'b1);
        vec++; if (op_count !== 4'd1) begin err++; $display("FAIL wrap_count got=%0d exp=1", op_count); end
        vec++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin err++; $display("FAIL wrap_cc_hold got=%b exp=100", {cc_zf, cc_sf, cc_of}); end
    endtask

    initial begin
        test_reset();
        test_flags();
        test_logic();
        test_backpressure();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
